// File: rtl/nasser_hadi_logic_pkg.sv
// Shared constants for the pipelined bitwise logic unit: op codes, pin field indices.
package nasser_hadi_logic_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NAND = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

  // uio_in control fields
  localparam int unsigned UIO_OP_LSB = 0;
  localparam int unsigned UIO_STROBE = 3;
  localparam int unsigned UIO_ACC    = 4;

  // uio_out status fields
  localparam int unsigned UIO_VALID  = 5;
  localparam int unsigned UIO_PARITY = 6;
  localparam int unsigned UIO_ZERO   = 7;

  localparam int unsigned OPB_LSB = 4;
  localparam int unsigned CNT_LSB = 4;

  localparam logic [7:0] UIO_OE = 8'b1110_0000;

endpackage

// File: rtl/nasser_hadi_logic_if.sv
// Tile pin bundle (everything except clk/rst_n) for the logic unit.
interface nasser_hadi_logic_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  modport master (
    output ena, ui_in, uio_in,
    input  uio_out, uio_oe, uo_out
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uio_out, uio_oe, uo_out
  );
endinterface

// File: rtl/nasser_hadi_gate_op.sv
// Combinational WIDTH-bit gate selected by a 3-bit op code.
module nasser_hadi_gate_op
  import nasser_hadi_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = b;
    case (op)
      OP_NAND: y = ~(x & b);
      OP_AND:  y = x & b;
      OP_OR:   y = x | b;
      OP_NOR:  y = ~(x | b);
      OP_XOR:  y = x ^ b;
      OP_XNOR: y = ~(x ^ b);
      OP_NOT:  y = ~x;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/tt_um_nasser_hadi_logic_unit.sv
// Two-stage pipelined bitwise logic unit with accumulate mode, flags and a
// wrapping transaction counter, packed onto the Tiny Tapeout tile pins.
module tt_um_nasser_hadi_logic_unit
  import nasser_hadi_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic             valid_out_q, valid_out_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             strobe_c;
  logic [WIDTH-1:0] x_c;
  logic [WIDTH-1:0] y_c;
  logic [7:0]       uo_c;
  logic [7:0]       uio_c;
  logic             unused_ok;

  assign strobe_c = uio_in[UIO_STROBE];

  // Accumulate mode feeds the live result register back as the left operand.
  assign x_c = acc_q ? result_q : a_q;

  nasser_hadi_gate_op #(.WIDTH(WIDTH)) u_gate (
    .x  (x_c),
    .b  (b_q),
    .op (op_q),
    .y  (y_c)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    acc_d       = acc_q;
    result_d    = result_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    valid_out_d = valid_out_q;
    count_d     = count_q;
    if (ena) begin
      s1_valid_d  = strobe_c;
      valid_out_d = s1_valid_q;
      if (strobe_c) begin
        a_d   = ui_in[WIDTH-1:0];
        b_d   = ui_in[OPB_LSB +: WIDTH];
        op_d  = uio_in[UIO_OP_LSB +: OP_W];
        acc_d = uio_in[UIO_ACC];
      end
      if (s1_valid_q) begin
        result_d = y_c;
        zero_d   = (y_c == '0);
        parity_d = ^y_c;
        count_d  = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      acc_q       <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      valid_out_q <= 1'b0;
      count_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      valid_out_q <= valid_out_d;
      count_q     <= count_d;
    end
  end

  // Pin packing; unused positions stay zero.
  always_comb begin
    uo_c                   = '0;
    uo_c[WIDTH-1:0]        = result_q;
    uo_c[CNT_LSB +: CNT_W] = count_q;
    uio_c                  = '0;
    uio_c[UIO_VALID]       = valid_out_q;
    uio_c[UIO_PARITY]      = parity_q;
    uio_c[UIO_ZERO]        = zero_q;
  end

  assign uo_out  = uo_c;
  assign uio_out = uio_c;
  assign uio_oe  = UIO_OE;

  assign unused_ok = ^{ui_in, uio_in[7:5]};

endmodule

// File: tb/tb_tt_um_nasser_hadi_logic_unit.sv
// Directed self-checking bench for the pipelined logic unit (default and narrow instances).
module tb_tt_um_nasser_hadi_logic_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nasser_hadi_logic_if if0 ();
  nasser_hadi_logic_if if1 ();

  tt_um_nasser_hadi_logic_unit #(.WIDTH(4), .CNT_W(4)) dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (if0.ena),
    .ui_in   (if0.ui_in),
    .uio_in  (if0.uio_in),
    .uio_out (if0.uio_out),
    .uio_oe  (if0.uio_oe),
    .uo_out  (if0.uo_out)
  );

  tt_um_nasser_hadi_logic_unit #(.WIDTH(2), .CNT_W(3)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (if1.ena),
    .ui_in   (if1.ui_in),
    .uio_in  (if1.uio_in),
    .uio_out (if1.uio_out),
    .uio_oe  (if1.uio_oe),
    .uo_out  (if1.uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // uio_in control byte: {acc, strobe, op}
  function automatic logic [7:0] ctl(input logic acc, input logic stb, input logic [2:0] op);
    return {3'b000, acc, stb, op};
  endfunction

  initial begin
    logic [3:0] res_tab [8];
    logic [3:0] r;
    res_tab = '{4'h7, 4'h8, 4'hE, 4'h1, 4'h6, 4'h9, 4'h5, 4'hC};
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    if0.ena = 1'b1; if0.ui_in = 8'h00; if0.uio_in = 8'h00;
    if1.ena = 1'b1; if1.ui_in = 8'h00; if1.uio_in = 8'h00;

    // Reset
    tick(); tick();
    chk("rst_uo", if0.uo_out, 8'h00);
    chk("rst_uio", if0.uio_out, 8'h00);
    chk("rst_oe", if0.uio_oe, 8'hE0);
    chk("rst_uo_w2", if1.uo_out, 8'h00);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_uo", if0.uo_out, 8'h00);
    chk("idle_uio", if0.uio_out, 8'h00);

    // All eight ops, A=0xA B=0xC, non-accumulate
    for (int i = 0; i < 8; i++) begin
      r = res_tab[i];
      if0.ui_in  = 8'hCA;
      if0.uio_in = ctl(1'b0, 1'b1, 3'(i));
      tick();
      if0.uio_in = 8'h00;
      chk($sformatf("op%0d_nv", i), if0.uio_out & 8'h20, 8'h00);
      tick();
      chk($sformatf("op%0d_uo", i), if0.uo_out, {4'(i + 1), r});
      chk($sformatf("op%0d_uio", i), if0.uio_out, {1'b0, ^r, 1'b1, 5'b0});
    end

    // Accumulate chain, back-to-back strobes
    if0.ui_in = 8'h30; if0.uio_in = ctl(1'b1, 1'b1, 3'd7);
    tick();
    if0.ui_in = 8'h50; if0.uio_in = ctl(1'b1, 1'b1, 3'd4);
    tick();
    chk("acc_pass", if0.uo_out, 8'h93);
    if0.ui_in = 8'hF0; if0.uio_in = ctl(1'b1, 1'b1, 3'd1);
    tick();
    chk("acc_xor", if0.uo_out, 8'hA6);
    chk("acc_xor_uio", if0.uio_out, 8'h20);
    if0.ui_in = 8'h90; if0.uio_in = ctl(1'b1, 1'b1, 3'd3);
    tick();
    chk("acc_and", if0.uo_out, 8'hB6);
    if0.uio_in = 8'h00;
    tick();
    chk("acc_nor", if0.uo_out, 8'hC0);
    chk("acc_nor_uio", if0.uio_out, 8'hA0);
    tick();
    chk("acc_idle_uio", if0.uio_out, 8'h80);

    // Count wrap over 17 continuous transactions
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_uo", if0.uo_out, 8'h00);
    for (int k = 0; k < 17; k++) begin
      if0.ui_in  = {4'(k), 4'h0};
      if0.uio_in = ctl(1'b0, 1'b1, 3'd7);
      tick();
      if (k > 0) begin
        chk($sformatf("wrap%0d_uo", k), if0.uo_out, {4'(k), 4'(k - 1)});
        chk($sformatf("wrap%0d_v", k), if0.uio_out & 8'h20, 8'h20);
      end
    end
    if0.uio_in = 8'h00;
    tick();
    chk("wrap_last_uo", if0.uo_out, 8'h10);
    chk("wrap_last_uio", if0.uio_out, 8'hA0);

    // ena stall: strobe during stall is ignored
    if0.ui_in = 8'h50; if0.uio_in = ctl(1'b0, 1'b1, 3'd7);
    tick();
    if0.ena = 1'b0;
    if0.ui_in = 8'h90;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("stall%0d_uo", s), if0.uo_out, 8'h10);
      chk($sformatf("stall%0d_uio", s), if0.uio_out, 8'h80);
    end
    if0.ena = 1'b1;
    if0.uio_in = 8'h00;
    tick();
    chk("stall_out_uo", if0.uo_out, 8'h25);
    chk("stall_out_uio", if0.uio_out, 8'h20);
    tick();
    chk("stall_after_uo", if0.uo_out, 8'h25);
    chk("stall_after_uio", if0.uio_out, 8'h00);

    // Reset on the edge after a strobe discards it
    if0.ui_in = 8'h70; if0.uio_in = ctl(1'b0, 1'b1, 3'd7);
    tick();
    rst_n = 1'b0; if0.uio_in = 8'h00;
    tick();
    rst_n = 1'b1;
    chk("midrst_uo", if0.uo_out, 8'h00);
    tick();
    chk("midrst_uo2", if0.uo_out, 8'h00);
    chk("midrst_uio2", if0.uio_out, 8'h00);

    // Reset and strobe on the same edge: reset wins
    rst_n = 1'b0; if0.uio_in = ctl(1'b0, 1'b1, 3'd7);
    tick();
    rst_n = 1'b1; if0.uio_in = 8'h00;
    tick();
    chk("rststb_uo", if0.uo_out, 8'h00);
    chk("rststb_uio", if0.uio_out, 8'h00);

    // Narrow instance: WIDTH=2, CNT_W=3, unused ui_in bits set
    if1.ui_in = 8'hDF; if1.uio_in = ctl(1'b0, 1'b1, 3'd0);
    tick();
    if1.uio_in = 8'h00;
    tick();
    chk("w2_uo", if1.uo_out, 8'h12);
    chk("w2_uio", if1.uio_out, 8'h60);
    chk("w2_oe", if1.uio_oe, 8'hE0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
